branch_pred_table: RTL
======================

# branch_pred_table

Pattern history table for the fetch-stage branch predictor. It holds one 2-bit saturating counter per (history context, PC index) pair. The 2-bit global history context from the ghr block selects one of four counter banks, and the fetch PC selects the entry within that bank. It produces a taken/untaken prediction for the fetch stage and trains the counters with branch outcomes resolved in the execute stage.

## Interface
- INDEX_WIDTH, 4, PC index bits per bank; each bank has 2^INDEX_WIDTH entries, 4 banks in total
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  reset, synchronous, active-high
- pc_f_i  in  32  fetch PC; lookup index = pc_f_i[INDEX_WIDTH+1:2]
- local_src_i  in  2  current history context from ghr; selects the lookup bank
- pc_e_i  in  32  PC of the branch in execute; update index = pc_e_i[INDEX_WIDTH+1:2]
- local_src_e_i  in  2  history context used when this branch was predicted, piped to execute; selects the update bank
- branch_op_e_i  in  2  bit 0 set = conditional branch in execute
- stall_e_i  in  1  execute stall; blocks training
- pc_src_res_e_i  in  1  resolved outcome: 1 = taken, 0 = not taken
- pred_taken_f_o  out  1  prediction for pc_f_i under local_src_i

## Operation
- Counter encoding: SN=00, WN=01, WT=10, ST=11.
- Prediction = bit 1 of the selected counter. The read is combinational from the registered array.
- Training enable: upd = branch_op_e_i[0] & ~stall_e_i & ~reset_i.
- When upd is high, the entry {local_src_e_i, pc_e_i index} changes as follows:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- All other entries hold their value.
- Only one entry is written per cycle. Lookup and update are independent ports.
- Aliasing is permitted. PCs that share index bits and context share a counter, with no tag check.
- Upper PC bits and bits [1:0] are ignored.

## Timing
- Reset: while reset_i is high at a rising edge, every counter loads WN (01). Training that cycle is discarded.
- After reset, pred_taken_f_o = 0 for every PC and context.
- Reset asserted mid-training overrides the pending update. No partial state is kept.
- Update latency: the counter write commits at the rising edge following the upd cycle. It is visible to lookups from that edge onward.
- Lookup latency: 0 cycles. pred_taken_f_o follows pc_f_i and local_src_i within the same cycle.
- If update and lookup hit the same entry in the same cycle, the behaviour is set by the Configuration section below.
- A branch_op_e_i[0] pulse held across stall_e_i trains exactly once: on the first cycle where stall_e_i is low.

## Configuration
- BPT_BYPASS_EN defined: on a same-cycle address match ({local_src_i, fetch index} == {local_src_e_i, execute index}) with upd high, pred_taken_f_o reflects the post-update counter value.
- BPT_BYPASS_EN undefined: pred_taken_f_o reflects the pre-update value. The new value becomes visible at the next cycle.

## Structure
- Shared package bp_pkg holds:
  - Counter state localparams SN/WN/WT/ST.
  - The reset value WN.
  - A sat_next(cnt, taken) function returning the saturated next value.
- The ghr block uses the same package for its state encodings.
- One natural sub-module: sat_counter_2b.
  - Ports: clk_i, reset_i, en, taken, cnt_o.
  - Instantiated 4*2^INDEX_WIDTH times via generate.
  - The top level holds the index decode, the read mux and the optional bypass.

## Test plan
- Reset: hold reset_i high for 1 cycle, then sweep all 16 indices x 4 contexts -> pred_taken_f_o = 0 everywhere.
- Training isolation: 2 taken updates at pc_e_i=0x10, local_src_e_i=11 -> that entry goes 01->10->11.
  - Lookup pc_f_i=0x10, local_src_i=11 gives 1 after the first update.
  - Same PC with local_src_i=00 still gives 0.
- Saturation: 5 taken updates then 1 not-taken at one entry -> 11 then 10, prediction stays 1. A second not-taken -> 01, prediction 0.
- Stall/gating:
  - Taken with stall_e_i=1 for 3 cycles, then stall_e_i=0 -> exactly one increment.
  - branch_op_e_i=2'b10 -> no change.
- Aliasing: train taken twice at pc_e_i=0x10 -> lookup pc_f_i=0x50 (index 4, same context) predicts 1.
- Bypass: entry at 01, same-cycle taken update and lookup of that entry:
  - BPT_BYPASS_EN defined -> pred_taken_f_o=1 in that cycle.
  - BPT_BYPASS_EN undefined -> 0 in that cycle, 1 in the next.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch predictor definitions: 2-bit counter states and saturating update.
package bp_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  localparam logic [1:0] CNT_RST = WN;

  // Next counter value after one resolved outcome, saturating at SN/ST.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == SN) ? SN : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// One 2-bit saturating pattern-history counter with synchronous reset to WN.
module sat_counter_2b
  import bp_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en,
  input  logic       taken,
  output logic [1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_o <= CNT_RST;
    end else if (en) begin
      cnt_o <= sat_next(cnt_o, taken);
    end
  end

endmodule

// File: rtl/branch_pred_table.sv
// Pattern history table: 4 context banks of 2-bit counters, combinational lookup,
// execute-stage training. Define BPT_BYPASS_EN to forward same-cycle updates to the lookup.
module branch_pred_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic [1:0]  local_src_i,
  input  logic [31:0] pc_e_i,
  input  logic [1:0]  local_src_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        stall_e_i,
  input  logic        pc_src_res_e_i,
  output logic        pred_taken_f_o
);

  localparam int unsigned ADDR_W      = INDEX_WIDTH + 2;
  localparam int unsigned NUM_ENTRIES = 1 << ADDR_W;

  logic [ADDR_W-1:0]      rd_addr;
  logic [ADDR_W-1:0]      wr_addr;
  logic                   upd;
  logic [NUM_ENTRIES-1:0] wr_sel;
  logic [1:0]             cnt [NUM_ENTRIES];

  // Context bits form the bank select above the PC word index; no tag, aliasing allowed.
  assign rd_addr = {local_src_i, pc_f_i[INDEX_WIDTH+1:2]};
  assign wr_addr = {local_src_e_i, pc_e_i[INDEX_WIDTH+1:2]};
  assign upd     = branch_op_e_i[0] & ~stall_e_i & ~reset_i;
  assign wr_sel  = upd ? (NUM_ENTRIES'(1) << wr_addr) : '0;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cnt
    sat_counter_2b u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en      (wr_sel[i]),
      .taken   (pc_src_res_e_i),
      .cnt_o   (cnt[i])
    );
  end

`ifdef BPT_BYPASS_EN
  logic [1:0] rd_cnt;

  // Forward the counter being trained this cycle when lookup hits the same entry.
  always_comb begin
    rd_cnt = cnt[rd_addr];
    if (upd && (rd_addr == wr_addr)) begin
      rd_cnt = sat_next(cnt[wr_addr], pc_src_res_e_i);
    end
  end

  assign pred_taken_f_o = rd_cnt[1];
`else
  assign pred_taken_f_o = cnt[rd_addr][1];
`endif

  logic unused_bits;
  assign unused_bits = ^{pc_f_i[31:INDEX_WIDTH+2], pc_f_i[1:0],
                         pc_e_i[31:INDEX_WIDTH+2], pc_e_i[1:0], branch_op_e_i[1]};

endmodule
